// File: rtl/gpio_irq_pkg.sv
// Package for the user-project GPIO edge/interrupt block.
// Holds the Wishbone register addresses, the register index encoding
// and a small helper that expands byte selects into a bit mask.
package gpio_irq_pkg;

    localparam int MPRJ_IO_PADS = 38;

    localparam logic [31:0] ADDR_EN_L    = 32'h300F_FFC0;
    localparam logic [31:0] ADDR_EN_H    = 32'h300F_FFC4;
    localparam logic [31:0] ADDR_EDGE_L  = 32'h300F_FFC8;
    localparam logic [31:0] ADDR_EDGE_H  = 32'h300F_FFCC;
    localparam logic [31:0] ADDR_STAT_L  = 32'h300F_FFD0;
    localparam logic [31:0] ADDR_STAT_H  = 32'h300F_FFD4;
    localparam logic [31:0] ADDR_LEVEL_L = 32'h300F_FFD8;
    localparam logic [31:0] ADDR_LEVEL_H = 32'h300F_FFDC;

    // Register index = {group, half}; half 0 = bits 31:0, half 1 = upper pads.
    localparam logic [1:0] GRP_EN    = 2'd0;
    localparam logic [1:0] GRP_EDGE  = 2'd1;
    localparam logic [1:0] GRP_STAT  = 2'd2;
    localparam logic [1:0] GRP_LEVEL = 2'd3;

    localparam logic [2:0] REG_EN_L    = 3'd0;
    localparam logic [2:0] REG_EN_H    = 3'd1;
    localparam logic [2:0] REG_EDGE_L  = 3'd2;
    localparam logic [2:0] REG_EDGE_H  = 3'd3;
    localparam logic [2:0] REG_STAT_L  = 3'd4;
    localparam logic [2:0] REG_STAT_H  = 3'd5;
    localparam logic [2:0] REG_LEVEL_L = 3'd6;
    localparam logic [2:0] REG_LEVEL_H = 3'd7;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pad synchroniser and edge detector.
// Each pad goes through two synchroniser flops (s1, s2) and a history
// flop (s3). Edges are derived from s2/s3 only.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset
//   i_pad  - raw pad inputs (asynchronous)
//   level  - synchronised pad level (s2)
//   rise   - s2 & ~s3
//   fall   - ~s2 & s3
module gpio_sync_edge #(
    parameter int WIDTH = 38
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pad,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;
    assign fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/user_project_gpio_irq.sv
// GPIO edge-detect interrupt controller with a Wishbone slave port.
// Enabled rising/falling pad edges latch into sticky status bits (W1C);
// irq is the registered OR of all status bits.
// Ports:
//   wb_clk_i, wb_rst_i          - clock, asynchronous active-high reset
//   wbs_stb_i/cyc_i/we_i/sel_i  - Wishbone request controls
//   wbs_dat_i, wbs_adr_i        - write data, byte address
//   wbs_ack_o, wbs_dat_o        - registered acknowledge and read data
//   io_in                       - raw pad inputs
//   irq                         - level interrupt
module user_project_gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int NPADS = MPRJ_IO_PADS
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPADS-1:0] io_in,
    output logic             irq
);

    logic [NPADS-1:0] r_en;
    logic [NPADS-1:0] r_edge;
    logic [NPADS-1:0] r_stat;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic             r_irq;

    logic [NPADS-1:0] w_level;
    logic [NPADS-1:0] w_rise;
    logic [NPADS-1:0] w_fall;
    logic [NPADS-1:0] w_hit;

    logic             w_adr_hit;
    logic [2:0]       w_idx;
    logic [1:0]       w_grp;
    logic             w_half;
    logic             w_req;
    logic             w_wr;
    logic [31:0]      w_bmask;
    logic [NPADS-1:0] w_mask;
    logic [NPADS-1:0] w_wdata;
    logic [NPADS-1:0] w_clr;
    logic [NPADS-1:0] w_rsel;
    logic [63:0]      w_rd64;
    logic [31:0]      w_rdata;

    gpio_sync_edge #(
        .WIDTH (NPADS)
    ) u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_pad (io_in),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_hit = r_en & ((r_edge & w_fall) | (~r_edge & w_rise));

    // Full 32-bit address decode.
    always_comb begin
        w_adr_hit = 1'b1;
        w_idx     = REG_EN_L;
        case (wbs_adr_i)
            ADDR_EN_L:    w_idx = REG_EN_L;
            ADDR_EN_H:    w_idx = REG_EN_H;
            ADDR_EDGE_L:  w_idx = REG_EDGE_L;
            ADDR_EDGE_H:  w_idx = REG_EDGE_H;
            ADDR_STAT_L:  w_idx = REG_STAT_L;
            ADDR_STAT_H:  w_idx = REG_STAT_H;
            ADDR_LEVEL_L: w_idx = REG_LEVEL_L;
            ADDR_LEVEL_H: w_idx = REG_LEVEL_H;
            default:      w_adr_hit = 1'b0;
        endcase
    end

    assign w_grp   = w_idx[2:1];
    assign w_half  = w_idx[0];
    assign w_req   = wbs_cyc_i & wbs_stb_i & ~r_ack & w_adr_hit;
    assign w_wr    = w_req & wbs_we_i;
    assign w_bmask = byte_mask(wbs_sel_i);

    // Map the 32-bit bus word onto the pad vector: pad i sits at bus bit
    // i mod 32 of whichever half the address selects.
    always_comb begin
        w_mask  = '0;
        w_wdata = '0;
        for (int unsigned i = 0; i < NPADS; i++) begin
            w_mask[i]  = ((i < 32) ? ~w_half : w_half) & w_bmask[i % 32];
            w_wdata[i] = wbs_dat_i[i % 32];
        end
    end

    assign w_clr = (w_wr && (w_grp == GRP_STAT)) ? (w_mask & w_wdata) : '0;

    always_comb begin
        w_rsel = '0;
        case (w_grp)
            GRP_EN:    w_rsel = r_en;
            GRP_EDGE:  w_rsel = r_edge;
            GRP_STAT:  w_rsel = r_stat;
            default:   w_rsel = w_level;
        endcase
    end

    assign w_rd64  = 64'(w_rsel);
    assign w_rdata = w_half ? w_rd64[63:32] : w_rd64[31:0];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_en   <= '0;
            r_edge <= '0;
        end else begin
            if (w_wr && (w_grp == GRP_EN))
                r_en <= (r_en & ~w_mask) | (w_wdata & w_mask);
            if (w_wr && (w_grp == GRP_EDGE))
                r_edge <= (r_edge & ~w_mask) | (w_wdata & w_mask);
        end
    end

    // Set has priority over a same-cycle W1C.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_hit;
            r_irq  <= |r_stat;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign irq       = r_irq;

endmodule

// File: tb/tb_user_project_gpio_irq.sv
module tb_user_project_gpio_irq;
    import gpio_irq_pkg::*;

    localparam int NP = 38;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          we  = 1'b0;
    logic [3:0]    sel = 4'h0;
    logic [31:0]   dat = 32'h0;
    logic [31:0]   adr = 32'h0;
    logic          ack;
    logic [31:0]   rdat;
    logic [NP-1:0] io  = '0;
    logic          irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    user_project_gpio_irq #(.NPADS(NP)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .io_in     (io),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every ack pops one expected data word.
    initial begin : monitor
        logic prev_ack;
        logic [31:0] e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack === 1'b1) begin
                total++;
                if (prev_ack) begin
                    bad++;
                    $display("FAIL ack_width: ack high %0d cycles, expected 1", 2);
                end
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: dat=%h, no request outstanding", rdat);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (rdat !== e) begin
                        bad++;
                        $display("FAIL rd_data @%h: got %h expected %h", adr, rdat, e);
                    end
                end
            end
            prev_ack = ack;
        end
    end

    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        int n;
        @(negedge clk);
        adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back(w ? 32'h0 : exp_rd);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 4);
        chk("ack_latency", 32'(n), 32'd1);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(a, 1'b1, s, d, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        bus(a, 1'b0, 4'hF, 32'h0, e);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] addrs [8];
        int acks;
        addrs = '{ADDR_EN_L, ADDR_EN_H, ADDR_EDGE_L, ADDR_EDGE_H,
                  ADDR_STAT_L, ADDR_STAT_H, ADDR_LEVEL_L, ADDR_LEVEL_H};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) rd(addrs[i], 32'h0);

        // Pad 0 rising edge
        wr(ADDR_EN_L, 32'h0000_0001, 4'hF);
        wr(ADDR_EDGE_L, 32'h0, 4'hF);
        io[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_before_n3", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_at_n3", 32'(irq), 32'd1);
        rd(ADDR_STAT_L, 32'h0000_0001);
        wr(ADDR_STAT_L, 32'h0000_0001, 4'hF);
        chk("irq_at_w1c_ack", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_after_w1c", 32'(irq), 32'd0);
        rd(ADDR_STAT_L, 32'h0);

        // Pad 37 falling-edge detection; unused H bits ignore writes
        wr(ADDR_EN_H, 32'h0000_0020, 4'hF);
        wr(ADDR_EDGE_H, 32'hFFFF_FFE0, 4'hF);
        rd(ADDR_EDGE_H, 32'h0000_0020);
        io[37] = 1'b1;
        repeat (4) @(negedge clk);
        rd(ADDR_STAT_H, 32'h0);
        rd(ADDR_LEVEL_H, 32'h0000_0020);
        io[37] = 1'b0;
        rd(ADDR_LEVEL_H, 32'h0000_0020);
        rd(ADDR_LEVEL_H, 32'h0);
        rd(ADDR_STAT_H, 32'h0000_0020);
        chk("irq_pad37", 32'(irq), 32'd1);
        wr(ADDR_STAT_H, 32'h0000_0020, 4'hF);
        rd(ADDR_STAT_H, 32'h0);

        // Byte-lane W1C
        wr(ADDR_EN_L, 32'h0000_0101, 4'hF);
        io[0] = 1'b0;
        repeat (4) @(negedge clk);
        io[0] = 1'b1;
        io[8] = 1'b1;
        repeat (4) @(negedge clk);
        rd(ADDR_LEVEL_L, 32'h0000_0101);
        rd(ADDR_STAT_L, 32'h0000_0101);
        wr(ADDR_STAT_L, 32'hFFFF_FFFF, 4'b0010);
        rd(ADDR_STAT_L, 32'h0000_0001);
        wr(ADDR_STAT_L, 32'hFFFF_FFFF, 4'hF);
        rd(ADDR_STAT_L, 32'h0);

        // Hit on pad 3 in the same cycle as its W1C
        wr(ADDR_EN_L, 32'h0000_0109, 4'hF);
        io[3] = 1'b1;
        @(negedge clk);
        wr(ADDR_STAT_L, 32'h0000_0008, 4'hF);
        @(posedge clk); #1;
        chk("irq_set_wins", 32'(irq), 32'd1);
        rd(ADDR_STAT_L, 32'h0000_0008);

        // Unmapped address
        @(negedge clk);
        adr = 32'h300F_FFE0; we = 1'b1; sel = 4'hF; dat = 32'hFFFF_FFFF;
        cyc = 1'b1; stb = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack === 1'b1) acks++;
        end
        chk("unmapped_ack", 32'(acks), 32'd0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat = 32'h0;
        rd(ADDR_STAT_L, 32'h0000_0008);
        rd(ADDR_EN_L, 32'h0000_0109);
        rd(ADDR_EDGE_L, 32'h0);

        // Reset asserted while ack is high
        @(negedge clk);
        adr = ADDR_EN_L; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("midack_ack_pre", 32'(ack), 32'd1);
        chk("midack_irq_pre", 32'(irq), 32'd1);
        rst = 1'b1;
        #1;
        chk("midack_ack_async", 32'(ack), 32'd0);
        chk("midack_irq_async", 32'(irq), 32'd0);
        chk("midack_dat_async", rdat, 32'h0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd(ADDR_STAT_L, 32'h0);
        rd(ADDR_EN_L, 32'h0);
        rd(ADDR_EDGE_H, 32'h0);
        chk("irq_after_reset", 32'(irq), 32'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/user_project_gpio_irq.md
# user_project_gpio_irq

Per-pad edge-detect and interrupt controller for the user project GPIO pads. It consumes `io_in` from the same pads the GPIO output/OEB register block drives, synchronises every pad to `wb_clk_i`, and latches enabled rising or falling edges into sticky status bits. Registers are accessed over the Wishbone slave port, and the block raises a single level interrupt toward the management core's user IRQ line.

## Interface
Parameters:
- `NPADS`, default `MPRJ_IO_PADS` (38): number of monitored pads. Must satisfy 33 ≤ NPADS ≤ 64. The high register half is NPADS-32 bits wide.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone strobe, cycle, write-enable.
- `wbs_sel_i`  in  4  byte selects, honoured on writes.
- `wbs_dat_i`  in  32  write data.
- `wbs_adr_i`  in  32  byte address, full 32-bit compare.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `io_in`  in  NPADS  raw pad inputs, asynchronous to `wb_clk_i`.
- `irq`  out  1  level interrupt, registered.

## Operation
Register map (L = bits 31:0, H = bits NPADS-1:32, right-aligned; unused H bits read 0 and ignore writes):
- 0x300FFFC0 EN_L, 0x300FFFC4 EN_H: per-pad interrupt enable, R/W.
- 0x300FFFC8 EDGE_L, 0x300FFFCC EDGE_H: per-pad edge select, 0 = rising, 1 = falling, R/W.
- 0x300FFFD0 STAT_L, 0x300FFFD4 STAT_H: sticky status. Writing 1 clears a bit; writing 0 has no effect.
- 0x300FFFD8 LEVEL_L, 0x300FFFDC LEVEL_H: synchronised pad level, read-only. Writes are acked and discarded.

Pad path:
- Each pad passes through a 2-flop synchroniser (s1, s2) and then a history flop (s3).
- rise = s2 & ~s3; fall = ~s2 & s3.
- hit[i] = EN[i] & (EDGE[i] ? fall[i] : rise[i]).
- STAT[i] is set on hit[i].
- `irq` is the registered OR of all STAT bits.

Bus:
- A request is cyc & stb & ~ack with an address in the map.
- Response: ack = 1 for exactly one cycle. On reads, `wbs_dat_o` carries the data; otherwise `wbs_dat_o` = 0.
- A write updates bytes with sel = 1 only. W1C on STAT is also per byte.
- Unmapped address: no ack and no state change.
- After an ack, the next request is accepted no earlier than the following cycle, because ~ack gates it.

Boundary rules:
- A hit and a W1C on the same bit in the same cycle: set wins, bit stays 1.
- Status only: clearing EN does not clear STAT.
- Changing EDGE or EN never creates a hit by itself. Detection uses s2/s3 only, and those always track the pads.
- Pulses narrower than one clock may be missed. Edges on a pad separated by at least 3 clocks are each detected.

## Timing
- Reset: all flops 0, including EN, EDGE, STAT, s1–s3, `wbs_ack_o`, `wbs_dat_o` and `irq`.
  - A pad held high through reset produces s2 = 1 with s3 = 0 for one cycle after reset.
  - EN = 0 at that point, so no status is set.
- Pad edge to STAT set: the edge is captured by s1 at clock N; STAT is set at N+2.
- `irq` follows STAT one cycle later, at N+3.
- Request to ack: the request is present at clock K; ack and data are registered at K+1. Ack drops at K+2.
- A W1C acked at K+1 sees STAT cleared at K+1 and `irq` low at K+2, unless another STAT bit is set or a new hit occurs.
- A reset assertion mid-transaction drops ack immediately (asynchronous) and clears all state.

## Structure
- Package `gpio_irq_pkg` holds:
  - the eight address constants;
  - register-index localparams.
- Sub-module `gpio_sync_edge` (parameter WIDTH) holds:
  - the s1/s2/s3 vectors;
  - outputs `level`, `rise`, `fall`.
- The top level holds the register file, the Wishbone decode and the irq flop.

## Test plan
- Reset, then read all eight addresses: every read returns 0x0. Each read's ack is high for exactly one cycle, on the cycle after the request.
- Write EN_L = 0x0000_0001, EDGE_L = 0, then drive `io_in[0]` 0→1: STAT_L = 0x1 three clocks after the edge and `irq` = 1 one cycle later. Then write 0x1 to STAT_L: `irq` returns to 0.
- Write EN_H = 0x20, EDGE_H = 0x20 and toggle `io_in[37]` 0→1→0: only the falling edge sets STAT_H = 0x20. Reading LEVEL_H tracks the pad with a 2-cycle lag.
- Write to STAT_L with `wbs_sel_i` = 4'b0010 and data 0xFFFF_FFFF while STAT_L = 0x0000_0101: STAT_L becomes 0x0000_0001, because only byte 1 is cleared.
- Make a hit on pad 3 coincide with a W1C of bit 3: STAT_L[3] remains 1 and `irq` stays high.
- Access address 0x300FFFE0: no ack for 4 cycles and no register changes. Assert `wb_rst_i` mid-ack: ack and `irq` drop without waiting for a clock edge.
